// File: rtl/pipelined_shift_unit.sv
// Pipelined barrel shifter/rotator with an elastic valid/ready pipeline.
// Each stage applies one bit of the shift count: stage k shifts by 2^k.
// A tag and an illegal-op flag travel with each op. Results leave in
// acceptance order after CNT_W cycles when the output is not stalled.

// One barrel stage. It shifts or rotates by a fixed amount when enabled
// and passes the operand through otherwise.
module pipelined_shift_unit_stage #(
    parameter int WIDTH = 16,
    parameter int SHAMT = 1
) (
    input  logic [WIDTH-1:0] operand,
    input  logic [2:0]       op,
    input  logic             en,
    output logic [WIDTH-1:0] result
);

    // Fixed-distance shift/rotate selected by op; identity when not enabled.
    always_comb begin
        result = operand;
        if (en) begin
            case (op)
                3'd0:    result = (operand << SHAMT) | (operand >> (WIDTH - SHAMT));
                3'd1:    result = operand << SHAMT;
                3'd2:    result = (operand >> SHAMT) | (operand << (WIDTH - SHAMT));
                3'd3:    result = operand >> SHAMT;
                // The sign bit never changes along an SRA chain, so the current
                // MSB is the original MSB of the operand.
                3'd4:    result = $unsigned($signed(operand) >>> SHAMT);
                default: result = operand;
            endcase
        end
    end

endmodule

module pipelined_shift_unit #(
    parameter  int WIDTH = 16,
    parameter  int TAG_W = 4,
    localparam int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [CNT_W-1:0] in_cnt,
    input  logic [2:0]       in_op,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_err
);

    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic [CNT_W-1:0] cnt;
        logic [2:0]       op;
        logic [TAG_W-1:0] tag;
        logic             err;
    } stage_t;

    stage_t           stg_q [CNT_W];   // stage registers
    stage_t           pin   [CNT_W];   // what each stage would load
    logic [WIDTH-1:0] sh_data [CNT_W]; // shifted data for each stage
    logic [CNT_W-1:0] v_q;             // per-stage valid
    logic [CNT_W-1:0] pv;              // predecessor valid
    logic [CNT_W-1:0] adv;             // stage may load this cycle
    logic             accept;
    logic             unused_ok;

    // A stage advances when it or any stage downstream of it is empty, or
    // the consumer takes the result; this is adv[k] = !v[k] || adv[k+1]
    // unrolled, so in_ready is a pure function of out_ready and v.
    always_comb begin
        logic acc;
        acc = out_ready;
        adv = '0;
        for (int k = CNT_W - 1; k >= 0; k--) begin
            acc    = acc || !v_q[k];
            adv[k] = acc;
        end
    end

    assign in_ready = adv[0];
    assign accept   = in_valid && in_ready;

    for (genvar k = 0; k < CNT_W; k++) begin : g_stage
        if (k == 0) begin : g_head
            assign pv[k]  = accept;
            assign pin[k] = '{data: in_data, cnt: in_cnt, op: in_op,
                              tag: in_tag, err: (in_op > 3'd4)};
        end else begin : g_body
            assign pv[k]  = v_q[k-1];
            assign pin[k] = stg_q[k-1];
        end

        // Illegal ops bypass every shift so the operand comes out untouched.
        pipelined_shift_unit_stage #(
            .WIDTH (WIDTH),
            .SHAMT (1 << k)
        ) u_stage (
            .operand (pin[k].data),
            .op      (pin[k].op),
            .en      (pin[k].cnt[k] && !pin[k].err),
            .result  (sh_data[k])
        );
    end

    // Elastic pipeline registers: advancing stages take the predecessor's
    // valid; payload only loads when a real op arrives, so held outputs
    // stay stable and empty slots keep their old contents.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q <= '0;
            for (int k = 0; k < CNT_W; k++) stg_q[k] <= '0;
        end else begin
            for (int k = 0; k < CNT_W; k++) begin
                if (adv[k]) begin
                    v_q[k] <= pv[k];
                    if (pv[k]) begin
                        stg_q[k] <= '{data: sh_data[k], cnt: pin[k].cnt, op: pin[k].op,
                                      tag: pin[k].tag, err: pin[k].err};
                    end
                end
            end
        end
    end

    assign out_valid = v_q[CNT_W-1];
    assign out_data  = stg_q[CNT_W-1].data;
    assign out_tag   = stg_q[CNT_W-1].tag;
    assign out_err   = stg_q[CNT_W-1].err;

    // The last stage's count and op are not needed after the final shift.
    assign unused_ok = ^{stg_q[CNT_W-1].cnt, stg_q[CNT_W-1].op};

endmodule

// File: tb/tb_pipelined_shift_unit.sv
// Directed + random scoreboard bench for pipelined_shift_unit at WIDTH=16.
module tb_pipelined_shift_unit;

    localparam int W  = 16;
    localparam int TW = 4;
    localparam int CW = $clog2(W);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid, in_ready, out_valid, out_ready, out_err;
    logic [W-1:0]  in_data, out_data;
    logic [CW-1:0] in_cnt;
    logic [2:0]    in_op;
    logic [TW-1:0] in_tag, out_tag;

    always #5 clk = ~clk;

    pipelined_shift_unit #(.WIDTH(W), .TAG_W(TW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_cnt    (in_cnt),
        .in_op     (in_op),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_tag   (out_tag),
        .out_err   (out_err)
    );

    typedef struct packed {
        logic [TW-1:0] tag;
        logic          err;
        logic [W-1:0]  data;
    } res_t;

    res_t sb[$];
    res_t pend;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   n_emit = 0;
    int   first_emit = -1;
    int   last_emit = -1;
    bit   acc_last, emit_last;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Reference: rotates via a doubled operand, shifts via the native operators.
    function automatic res_t model(input logic [W-1:0] d, input logic [CW-1:0] c,
                                   input logic [2:0] op, input logic [TW-1:0] t);
        res_t           r;
        logic [2*W-1:0] dd, tmp;
        dd    = {d, d};
        r.tag = t;
        r.err = 1'b0;
        case (op)
            3'd0:    begin tmp = dd >> (W - int'(c)); r.data = tmp[W-1:0]; end
            3'd1:    r.data = d << c;
            3'd2:    begin tmp = dd >> c; r.data = tmp[W-1:0]; end
            3'd3:    r.data = d >> c;
            3'd4:    r.data = $unsigned($signed(d) >>> c);
            default: begin r.err = 1'b1; r.data = d; end
        endcase
        return r;
    endfunction

    // One clock: observe handshakes at the negedge, score them, step past posedge.
    task automatic cycle();
        res_t e;
        @(negedge clk);
        acc_last  = in_valid && in_ready;
        emit_last = out_valid && out_ready;
        if (emit_last) begin
            check("sb_has_entry", 64'(sb.size() != 0), 64'(1));
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("result", 64'({out_tag, out_err, out_data}), 64'(e));
            end
            n_emit++;
            if (first_emit < 0) first_emit = cyc;
            last_emit = cyc;
        end
        if (acc_last) sb.push_back(pend);
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic set_op(input logic [W-1:0] d, input logic [CW-1:0] c,
                          input logic [2:0] op, input logic [TW-1:0] t);
        in_valid = 1'b1; in_data = d; in_cnt = c; in_op = op; in_tag = t;
        pend = model(d, c, op, t);
    endtask

    task automatic set_exp(input logic [W-1:0] d, input logic [CW-1:0] c, input logic [2:0] op,
                           input logic [TW-1:0] t, input logic [W-1:0] ed, input logic ee);
        in_valid = 1'b1; in_data = d; in_cnt = c; in_op = op; in_tag = t;
        pend = '{tag: t, err: ee, data: ed};
    endtask

    task automatic hold_accept();
        int n = 0;
        do begin cycle(); n++; end while (!acc_last && n < 50);
        check("accept", 64'(acc_last), 64'(1));
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        out_ready = 1'b1;
        in_valid  = 1'b0;
        while (sb.size() != 0 && n < 200) begin cycle(); n++; end
        repeat (CW + 1) cycle();
        check("drained", 64'(sb.size()), 64'(0));
    endtask

    initial begin
        int          lat, nacc, start;
        logic [W-1:0] v, d0;
        in_valid = 1'b0; in_data = '0; in_cnt = '0; in_op = '0; in_tag = '0;
        out_ready = 1'b1;
        pend = '0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_out_data",  64'(out_data),  64'(0));
        check("rst_out_tag",   64'(out_tag),   64'(0));
        check("rst_out_err",   64'(out_err),   64'(0));
        rst_n = 1'b1;
        #1;
        check("rst_in_ready",  64'(in_ready),  64'(1));

        // Latency of a single SRL 0x8001 >> 15
        set_exp(16'h8001, 4'd15, 3'd3, 4'd0, 16'h0001, 1'b0);
        hold_accept();
        lat = 1;
        while (!out_valid && lat < 20) begin cycle(); lat++; end
        check("latency", 64'(lat), 64'(CW));
        drain();

        // Legacy logical-right shifter over every count
        v = 16'h8001;
        for (int c = 0; c < 16; c++) begin
            set_exp(v, CW'(c), 3'd3, TW'(c), v >> c, 1'b0);
            hold_accept();
        end
        drain();

        // Fill and wrap cases
        set_exp(16'h8000, 4'd3, 3'd4, 4'd1, 16'hF000, 1'b0); hold_accept();
        set_exp(16'h0001, 4'd1, 3'd2, 4'd2, 16'h8000, 1'b0); hold_accept();
        set_exp(16'h8001, 4'd4, 3'd0, 4'd3, 16'h0018, 1'b0); hold_accept();
        set_exp(16'hFFFF, 4'd8, 3'd1, 4'd4, 16'hFF00, 1'b0); hold_accept();
        set_exp(16'hA5C3, 4'd0, 3'd0, 4'd5, 16'hA5C3, 1'b0); hold_accept();
        drain();

        // Back-to-back stream of 20 ops
        n_emit = 0; first_emit = -1; start = cyc;
        for (int i = 0; i < 20; i++) begin
            set_op(W'($urandom), CW'(i), 3'(i % 5), TW'(i));
            hold_accept();
        end
        check("stream_accept_cycles", 64'(cyc - start), 64'(20));
        drain();
        check("stream_emits", 64'(n_emit), 64'(20));
        check("stream_no_gaps", 64'(last_emit - first_emit), 64'(19));

        // Stall: pipe compresses, then resumes with accept and emit together
        out_ready = 1'b0; nacc = 0;
        set_op(16'h1357, 4'd2, 3'd0, 4'd8);
        for (int i = 0; i < 10; i++) begin
            cycle();
            if (acc_last) begin
                nacc++;
                set_op(W'($urandom), CW'($urandom), 3'($urandom_range(0, 4)), TW'(9 + nacc));
            end
        end
        check("stall_accepts", 64'(nacc), 64'(CW));
        check("stall_in_ready", 64'(in_ready), 64'(0));
        check("stall_out_valid", 64'(out_valid), 64'(1));
        d0 = out_data;
        cycle(); cycle();
        check("stall_data_stable", 64'(out_data), 64'(d0));
        out_ready = 1'b1;
        cycle();
        check("accept_with_emit", 64'({acc_last, emit_last}), 64'(2'b11));
        drain();

        // Illegal op passes data through, in order
        set_op(16'h00F0, 4'd4, 3'd1, 4'd1); hold_accept();
        set_exp(16'h1234, 4'd5, 3'b110, 4'd2, 16'h1234, 1'b1); hold_accept();
        set_op(16'h00F0, 4'd4, 3'd2, 4'd3); hold_accept();
        drain();

        // Reset with ops in flight
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            set_op(W'($urandom), CW'(i + 1), 3'd1, TW'(i));
            hold_accept();
        end
        repeat (3) cycle();
        check("pre_reset_valid", 64'(out_valid), 64'(1));
        rst_n = 1'b0;
        #1;
        check("reset_out_valid", 64'(out_valid), 64'(0));
        sb.delete();
        #2;
        rst_n = 1'b1;
        out_ready = 1'b1;
        n_emit = 0;
        repeat (10) cycle();
        check("no_stale_results", 64'(n_emit), 64'(0));

        // Random ops with random backpressure
        in_valid = 1'b0;
        for (int i = 0; i < 300; i++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            if (!in_valid && $urandom_range(0, 1) == 1)
                set_op(W'($urandom), CW'($urandom), 3'($urandom_range(0, 7)), TW'($urandom));
            cycle();
            if (acc_last) in_valid = 1'b0;
        end
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
